// File: rtl/interval_timer.sv
// Programmable interval timer with toggle, periodic and one-shot modes.
// A down-counter reloads with the period latched at start; each expiry emits a one-cycle tick.
module interval_timer #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned WIDTH      = 26,
    parameter int unsigned DEF_PERIOD = CLK_HZ
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             pause_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] period_i,
    output logic             tick_o,
    output logic             finish_o,
    output logic             counting_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] count_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED
    } state_t;

    typedef enum logic [1:0] {
        MODE_TOGGLE,
        MODE_PERIODIC,
        MODE_ONESHOT,
        MODE_RSVD
    } mode_t;

    localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEF_PERIOD);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    // Catch parameter sets the datapath cannot represent.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("interval_timer: WIDTH must be in 2..32");
    end
    if (DEF_PERIOD == 0 || (WIDTH < 32 && DEF_PERIOD >= (32'd1 << WIDTH))) begin : g_bad_def
        $error("interval_timer: DEF_PERIOD must be nonzero and fit in WIDTH bits");
    end

    state_t           state;
    mode_t            mode_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] period_eff_c;

    assign period_eff_c = (period_i == '0) ? DEF_P : period_i;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_TOGGLE;
            period_q   <= DEF_P;
            count_o    <= '0;
            tick_o     <= 1'b0;
            finish_o   <= 1'b0;
            counting_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            tick_o <= 1'b0;
            if (stop_i) begin
                state      <= ST_IDLE;
                count_o    <= '0;
                counting_o <= 1'b0;
                busy_o     <= 1'b0;
            end else if (start_i) begin
                state      <= ST_RUN;
                mode_q     <= mode_t'(mode_i);
                period_q   <= period_eff_c;
                count_o    <= period_eff_c - ONE;
                finish_o   <= 1'b0;
                counting_o <= 1'b1;
                busy_o     <= 1'b1;
            end else begin
                case (state)
                    ST_RUN, ST_PAUSED: begin
                        if (pause_i) begin
                            if (state == ST_RUN) begin
                                state <= ST_PAUSED;
                                if (mode_q != MODE_TOGGLE) begin
                                    counting_o <= 1'b0;
                                end
                            end
                        end else begin
                            // Resuming from PAUSED counts on the same edge, so no cycle is lost.
                            state <= ST_RUN;
                            if (mode_q != MODE_TOGGLE) begin
                                counting_o <= 1'b1;
                            end
                            if (count_o != '0) begin
                                count_o <= count_o - ONE;
                            end else begin
                                tick_o <= 1'b1;
                                case (mode_q)
                                    MODE_TOGGLE: begin
                                        count_o    <= period_q - ONE;
                                        finish_o   <= ~finish_o;
                                        counting_o <= ~counting_o;
                                    end
                                    MODE_ONESHOT: begin
                                        state      <= ST_IDLE;
                                        finish_o   <= 1'b1;
                                        counting_o <= 1'b0;
                                        busy_o     <= 1'b0;
                                    end
                                    default: begin
                                        count_o    <= period_q - ONE;
                                        finish_o   <= 1'b1;
                                        counting_o <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_interval_timer.sv
// Randomized scoreboard bench for interval_timer against an elapsed-cycle reference model.
module tb_interval_timer;

    localparam int unsigned W   = 26;
    localparam int unsigned DEF = 50_000_000;

    typedef struct packed {
        logic         tick;
        logic         finish;
        logic         counting;
        logic         busy;
        logic [W-1:0] count;
    } obs_t;

    typedef struct {
        obs_t  o;
        string tag;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start_i = 1'b0;
    logic         stop_i = 1'b0;
    logic         pause_i = 1'b0;
    logic [1:0]   mode_i = 2'd0;
    logic [W-1:0] period_i = '0;
    logic         tick_o, finish_o, counting_o, busy_o;
    logic [W-1:0] count_o;

    interval_timer #(.CLK_HZ(DEF), .WIDTH(W), .DEF_PERIOD(DEF)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .pause_i    (pause_i),
        .mode_i     (mode_i),
        .period_i   (period_i),
        .tick_o     (tick_o),
        .finish_o   (finish_o),
        .counting_o (counting_o),
        .busy_o     (busy_o),
        .count_o    (count_o)
    );

    always #5 clock = ~clock;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    // Reference model: active/paused flags plus cycles elapsed in the current interval.
    bit          m_act, m_pau, m_fin, m_cnt, m_tick;
    int unsigned m_mode, m_p, m_el;

    function automatic void model_reset();
        m_act = 0; m_pau = 0; m_fin = 0; m_cnt = 0; m_tick = 0;
        m_mode = 0; m_p = DEF; m_el = 0;
    endfunction

    function automatic void model_step(bit st, bit sp, bit pa, int unsigned md, int unsigned per);
        m_tick = 0;
        if (sp) begin
            m_act = 0; m_pau = 0; m_cnt = 0;
        end else if (st) begin
            m_act = 1; m_pau = 0; m_el = 0; m_fin = 0; m_cnt = 1;
            m_mode = (md == 3) ? 1 : md;
            m_p = (per == 0) ? DEF : per;
        end else if (m_act && pa && !m_pau) begin
            m_pau = 1;
            if (m_mode != 0) m_cnt = 0;
        end else if (m_act && !(pa && m_pau)) begin
            m_pau = 0;
            if (m_mode != 0) m_cnt = 1;
            if (m_el + 1 == m_p) begin
                m_tick = 1;
                m_el = 0;
                if (m_mode == 0) begin
                    m_fin = !m_fin; m_cnt = !m_cnt;
                end else if (m_mode == 1) begin
                    m_fin = 1;
                end else begin
                    m_fin = 1; m_cnt = 0; m_act = 0;
                end
            end else begin
                m_el++;
            end
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.tick     = m_tick;
        o.finish   = m_fin;
        o.counting = m_cnt;
        o.busy     = m_act;
        o.count    = m_act ? W'(m_p - 1 - m_el) : '0;
        return o;
    endfunction

    function automatic void compare(obs_t want, string tag);
        obs_t got;
        got = '{tick: tick_o, finish: finish_o, counting: counting_o, busy: busy_o, count: count_o};
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got tick=%b fin=%b cnt=%b busy=%b count=%0d, want tick=%b fin=%b cnt=%b busy=%b count=%0d",
                     tag, $time, got.tick, got.finish, got.counting, got.busy, got.count,
                     want.tick, want.finish, want.counting, want.busy, want.count);
        end
    endfunction

    // Monitor: one expected observation per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compare(e.o, e.tag);
            end
        end
    end

    task automatic cycle(input bit rn, input bit st, input bit sp, input bit pa,
                         input logic [1:0] md, input int unsigned per, input string tag);
        exp_t e;
        @(negedge clock);
        reset_n  = rn;
        start_i  = st;
        stop_i   = sp;
        pause_i  = pa;
        mode_i   = md;
        period_i = W'(per);
        if (!rn) model_reset();
        else     model_step(st, sp, pa, md, per);
        e.o   = model_obs();
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++)
            cycle(1, 0, 0, 0, 2'($urandom_range(0, 3)), $urandom_range(0, 15), tag);
    endtask

    initial begin
        model_reset();
        #1;
        compare(model_obs(), "reset_time0");

        cycle(0, 0, 0, 0, 0, 0, "reset");
        cycle(0, 1, 0, 1, 1, 4, "reset_held");
        cycle(1, 0, 0, 1, 0, 0, "idle_pause");
        cycle(1, 0, 0, 1, 2, 7, "idle_pause");

        cycle(1, 1, 0, 0, 1, 4, "periodic4_start");
        idle(12, "periodic4");

        cycle(1, 1, 0, 0, 0, 3, "toggle3_start");
        idle(9, "toggle3");

        cycle(1, 1, 0, 0, 2, 5, "oneshot5_start");
        idle(8, "oneshot5");

        cycle(1, 1, 0, 0, 1, 8, "pause_start");
        idle(2, "pause_pre");
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 0, 2, "pause_hold");
        idle(10, "pause_post");

        cycle(1, 1, 0, 0, 3, 6, "startstop_start");
        idle(2, "startstop_run");
        cycle(1, 1, 1, 0, 1, 6, "startstop_both");
        idle(2, "startstop_idle");

        cycle(1, 1, 0, 0, 1, 0, "defperiod_start");
        idle(3, "defperiod_run");

        cycle(1, 1, 0, 0, 1, 3, "asyncrst_start");
        idle(4, "asyncrst_run");
        @(negedge clock);
        #3 reset_n = 1'b0;
        model_reset();
        #1 compare(model_obs(), "asyncrst_immediate");
        cycle(0, 0, 0, 0, 1, 3, "asyncrst_held");
        cycle(1, 0, 0, 0, 1, 3, "asyncrst_release");
        idle(5, "asyncrst_after");

        for (int i = 0; i < 4000; i++) begin
            bit rn, st, sp, pa;
            int unsigned per;
            rn  = ($urandom_range(0, 499) != 0);
            st  = ($urandom_range(0, 24) == 0);
            sp  = ($urandom_range(0, 59) == 0);
            pa  = ($urandom_range(0, 5) == 0);
            per = ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 10);
            cycle(rn, st, sp, pa, 2'($urandom_range(0, 3)), per, "random");
        end

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending observations, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
